// File: rtl/ip_header_tx.sv
// IPv4 header serialiser: emits a fixed 20-byte header (no options) one byte per
// clock, computing the header checksum from values latched at the start pulse.
module ip_header_tx #(
  parameter logic [7:0]  TTL     = 8'd64,
  parameter logic        DF      = 1'b1,
  parameter logic [15:0] ID_INIT = 16'h0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        mac_header_tx_done,
  input  logic [15:0] udp_len,
  input  logic [31:0] ip_s,
  input  logic [31:0] ip_d,
  output logic [7:0]  data_out,
  output logic        ip_header_tx_done,
  output logic        busy
);

  typedef enum logic {
    WAIT_START = 1'b0,
    HDR_TX     = 1'b1
  } state_t;

  localparam logic [4:0]  LAST_BYTE  = 5'd19;
  localparam logic [15:0] VER_IHL    = 16'h4500;
  localparam logic [15:0] HDR_UDP    = 16'd28;
  localparam logic [15:0] FLAGS_FRAG = {1'b0, DF, 14'd0};
  localparam logic [15:0] TTL_PROTO  = {TTL, 8'h11};

  state_t      state, state_nxt;
  logic [4:0]  byte_cnt, byte_cnt_nxt;
  logic        start;
  logic        last;

  logic [15:0] len_q;
  logic [15:0] id_q;
  logic [15:0] id_cnt;
  logic [31:0] src_q;
  logic [31:0] dst_q;

  logic [15:0] total_len;
  logic [19:0] sum_raw;
  logic [19:0] sum_q;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [15:0] csum_q;
  logic [15:0] hdr_word;

  function automatic logic [19:0] ext(input logic [15:0] w);
    return {4'd0, w};
  endfunction

  assign start     = (state == WAIT_START) && mac_header_tx_done;
  assign last      = (state == HDR_TX) && (byte_cnt == LAST_BYTE);
  assign total_len = len_q + HDR_UDP;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= WAIT_START;
      byte_cnt <= 5'd0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt         = state;
    byte_cnt_nxt      = byte_cnt;
    data_out          = 8'h00;
    ip_header_tx_done = 1'b0;
    busy              = 1'b0;
    case (state)
      WAIT_START: begin
        if (mac_header_tx_done) begin
          state_nxt    = HDR_TX;
          byte_cnt_nxt = 5'd0;
        end
      end
      HDR_TX: begin
        busy     = 1'b1;
        data_out = byte_cnt[0] ? hdr_word[7:0] : hdr_word[15:8];
        if (byte_cnt == LAST_BYTE) begin
          ip_header_tx_done = 1'b1;
          state_nxt         = WAIT_START;
          byte_cnt_nxt      = 5'd0;
        end else begin
          byte_cnt_nxt = byte_cnt + 5'd1;
        end
      end
      default: state_nxt = WAIT_START;
    endcase
  end

  // Header fields are frozen at start so later input changes cannot corrupt a frame.
  always_ff @(posedge aclk) begin
    if (areset) begin
      len_q  <= 16'd0;
      id_q   <= 16'd0;
      src_q  <= 32'd0;
      dst_q  <= 32'd0;
      id_cnt <= ID_INIT;
    end else begin
      if (start) begin
        len_q <= udp_len;
        id_q  <= id_cnt;
        src_q <= ip_s;
        dst_q <= ip_d;
      end
      if (last) begin
        id_cnt <= id_cnt + 16'd1;
      end
    end
  end

  // Checksum pipeline: raw sum during byte 0, fold/invert during byte 1; ready long
  // before byte 10 needs it.
  assign sum_raw = ext(VER_IHL) + ext(total_len) + ext(id_q) + ext(FLAGS_FRAG)
                 + ext(TTL_PROTO) + ext(src_q[31:16]) + ext(src_q[15:0])
                 + ext(dst_q[31:16]) + ext(dst_q[15:0]);

  assign fold1 = {1'b0, sum_q[15:0]} + {13'd0, sum_q[19:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

  always_ff @(posedge aclk) begin
    if (areset) begin
      sum_q  <= 20'd0;
      csum_q <= 16'd0;
    end else if (state == HDR_TX) begin
      if (byte_cnt == 5'd0) sum_q  <= sum_raw;
      if (byte_cnt == 5'd1) csum_q <= ~fold2;
    end
  end

  always_comb begin
    hdr_word = 16'h0000;
    case (byte_cnt[4:1])
      4'd0:    hdr_word = VER_IHL;
      4'd1:    hdr_word = total_len;
      4'd2:    hdr_word = id_q;
      4'd3:    hdr_word = FLAGS_FRAG;
      4'd4:    hdr_word = TTL_PROTO;
      4'd5:    hdr_word = csum_q;
      4'd6:    hdr_word = src_q[31:16];
      4'd7:    hdr_word = src_q[15:0];
      4'd8:    hdr_word = dst_q[31:16];
      4'd9:    hdr_word = dst_q[15:0];
      default: hdr_word = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_ip_header_tx.sv
// Directed bench for ip_header_tx: expected per-cycle outputs are queued when a start
// is driven and compared one cycle at a time as the header streams out.
module tb_ip_header_tx;

  localparam logic [15:0] ID_INIT = 16'h0000;

  logic        aclk = 1'b0;
  logic        areset;
  logic        mac_header_tx_done;
  logic [15:0] udp_len;
  logic [31:0] ip_s;
  logic [31:0] ip_d;
  logic [7:0]  data_out;
  logic        ip_header_tx_done;
  logic        busy;

  ip_header_tx #(
    .TTL    (8'd64),
    .DF     (1'b1),
    .ID_INIT(ID_INIT)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .mac_header_tx_done(mac_header_tx_done),
    .udp_len           (udp_len),
    .ip_s              (ip_s),
    .ip_d              (ip_d),
    .data_out          (data_out),
    .ip_header_tx_done (ip_header_tx_done),
    .busy              (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [7:0] data;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] model_id;
  logic [7:0]  nom [20] = '{8'h45, 8'h00, 8'h00, 8'h2C, 8'h00, 8'h00, 8'h40, 8'h00,
                            8'h40, 8'h11, 8'hB7, 8'h65, 8'hC0, 8'hA8, 8'h01, 8'h0A,
                            8'hC0, 8'hA8, 8'h01, 8'h01};

  // Empty scoreboard means the DUT must be idle this cycle.
  always @(posedge aclk) begin
    exp_t e;
    #1;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    total++;
    assert (data_out === e.data) else begin
      bad++;
      $error("FAIL data_out t=%0t got=%h exp=%h", $time, data_out, e.data);
    end
    total++;
    assert (ip_header_tx_done === e.done) else begin
      bad++;
      $error("FAIL done t=%0t got=%b exp=%b", $time, ip_header_tx_done, e.done);
    end
    total++;
    assert (busy === e.busy) else begin
      bad++;
      $error("FAIL busy t=%0t got=%b exp=%b", $time, busy, e.busy);
    end
  end

  task automatic build_frame(input logic [15:0] len, input logic [31:0] s,
                             input logic [31:0] d, input logic [15:0] id,
                             output logic [7:0] b [20]);
    logic [15:0] w [10];
    logic [31:0] acc;
    w[0] = 16'h4500;
    w[1] = len + 16'd28;
    w[2] = id;
    w[3] = 16'h4000;
    w[4] = 16'h4011;
    w[5] = 16'h0000;
    w[6] = s[31:16];
    w[7] = s[15:0];
    w[8] = d[31:16];
    w[9] = d[15:0];
    acc = 32'd0;
    for (int i = 0; i < 10; i++) acc = acc + {16'd0, w[i]};
    while (acc[31:16] != 16'd0) acc = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
    w[5] = ~acc[15:0];
    for (int i = 0; i < 10; i++) begin
      b[2*i]   = w[i][15:8];
      b[2*i+1] = w[i][7:0];
    end
  endtask

  task automatic push_frame(input logic [7:0] b [20]);
    exp_t e;
    for (int k = 0; k < 20; k++) begin
      e.data = b[k];
      e.done = (k == 19);
      e.busy = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic push_model();
    logic [7:0] b [20];
    build_frame(udp_len, ip_s, ip_d, model_id, b);
    push_frame(b);
    model_id = model_id + 16'd1;
  endtask

  task automatic pulse_start();
    mac_header_tx_done = 1'b1;
    @(negedge aclk);
    mac_header_tx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  initial begin
    logic [7:0] b2 [20];
    areset             = 1'b1;
    mac_header_tx_done = 1'b0;
    udp_len            = 16'h0010;
    ip_s               = 32'hC0A8010A;
    ip_d               = 32'hC0A80101;
    model_id           = ID_INIT;
    idle(3);
    areset = 1'b0;
    idle(2);

    // Nominal frame, then a back-to-back frame started the cycle after byte 19.
    push_frame(nom);
    model_id = model_id + 16'd1;
    pulse_start();
    idle(20);
    b2     = nom;
    b2[5]  = 8'h01;
    b2[10] = 8'hB7;
    b2[11] = 8'h64;
    push_frame(b2);
    model_id = model_id + 16'd1;
    pulse_start();
    idle(22);

    // Inputs change two cycles after start; frame must reflect latched values.
    udp_len = 16'h0123;
    ip_s    = 32'h0A000001;
    ip_d    = 32'hFFFFFFFE;
    push_model();
    pulse_start();
    @(negedge aclk);
    udp_len = 16'hBEEF;
    ip_s    = 32'h12345678;
    ip_d    = 32'h9ABCDEF0;
    idle(21);

    // total_len wrap boundaries.
    udp_len = 16'hFFE3;
    push_model();
    pulse_start();
    idle(22);
    udp_len = 16'hFFE4;
    push_model();
    pulse_start();
    idle(22);

    // Starts during busy and in the byte-19 cycle must be ignored.
    udp_len = 16'h0040;
    ip_s    = 32'hAC100001;
    ip_d    = 32'hAC1000FE;
    push_model();
    pulse_start();
    idle(3);
    pulse_start();
    idle(15);
    pulse_start();
    idle(4);

    // Reset while byte 7 is on the bus, then a fresh frame with ID_INIT.
    push_model();
    pulse_start();
    idle(7);
    areset = 1'b1;
    sb.delete();
    model_id = ID_INIT;
    @(negedge aclk);
    areset = 1'b0;
    idle(3);
    push_model();
    pulse_start();
    idle(24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
